// File: rtl/dma_arbiter_pkg.sv
// rtl/dma_arbiter_pkg.sv - shared state type and default sizing for the DMA channel arbiter
package dma_arbiter_pkg;

  localparam int DMA_CHANNELS    = 4;
  localparam int DMA_BURST_LIMIT = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    GRANT,
    RELEASE
  } dma_arb_state_t;

endpackage

// File: rtl/dma_priority_picker.sv
// rtl/dma_priority_picker.sv - combinational first-pending search starting at a given index
module dma_priority_picker #(
  parameter  int CHANNELS = 4,
  localparam int IW       = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] pending,
  input  logic [IW-1:0]       start,
  output logic [IW-1:0]       winner,
  output logic                valid
);

  // Walk the channels circularly from start; the first pending one wins.
  always_comb begin
    int idx;
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(start) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!valid && pending[idx]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// rtl/dma_channel_arbiter.sv - HOLD/DACK bus arbiter for DMA channels; option DMA_ROTATING_PRIORITY_EN
module dma_channel_arbiter
  import dma_arbiter_pkg::*;
#(
  parameter  int CHANNELS    = DMA_CHANNELS,
  parameter  int BURST_LIMIT = DMA_BURST_LIMIT,
  localparam int IW          = $clog2(CHANNELS),
  localparam int CW          = $clog2(BURST_LIMIT + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] dma_request,
  input  logic [CHANNELS-1:0] channel_mask,
  input  logic                hold_acknowledge,
  input  logic                transfer_done,
  input  logic                terminal_count,
  input  logic                status_read,
  output logic                hold_request,
  output logic [CHANNELS-1:0] dma_acknowledge_n,
  output logic [IW-1:0]       active_channel,
  output logic                bus_owned,
  output logic [CHANNELS-1:0] terminal_count_status
);

  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LIMIT - 1);

  dma_arb_state_t      state, state_d;
  logic [CW-1:0]       burst_cnt, burst_cnt_d;
  logic                hrq_d, owned_d;
  logic [CHANNELS-1:0] dack_d, tcs_d;
  logic [IW-1:0]       active_d;

  logic [CHANNELS-1:0] pending;
  logic [IW-1:0]       pick_start, pick_winner;
  logic                pick_valid;

  assign pending = dma_request & ~channel_mask;

`ifdef DMA_ROTATING_PRIORITY_EN
  logic [IW-1:0] last_granted;
  logic          grant_taken;

  assign grant_taken = (state == REQUEST) && hold_acknowledge && pick_valid;
  assign pick_start  = (last_granted == IW'(CHANNELS - 1)) ? '0 : last_granted + 1'b1;

  // Remember the most recent grant so it drops to lowest priority next time.
  always_ff @(posedge clock) begin
    if (!reset_n) last_granted <= IW'(CHANNELS - 1);
    else if (grant_taken) last_granted <= pick_winner;
  end
`else
  assign pick_start = '0;
`endif

  dma_priority_picker #(.CHANNELS(CHANNELS)) u_picker (
    .pending (pending),
    .start   (pick_start),
    .winner  (pick_winner),
    .valid   (pick_valid)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state;
    hrq_d       = hold_request;
    dack_d      = dma_acknowledge_n;
    active_d    = active_channel;
    owned_d     = bus_owned;
    burst_cnt_d = burst_cnt;
    tcs_d       = status_read ? '0 : terminal_count_status;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          active_d = pick_winner;
          hrq_d    = 1'b1;
          state_d  = REQUEST;
        end
      end
      REQUEST: begin
        // HRQ stays up until the CPU answers, even if demand vanished.
        if (hold_acknowledge) begin
          if (pick_valid) begin
            active_d    = pick_winner;
            dack_d      = ~(CHANNELS'(1) << pick_winner);
            owned_d     = 1'b1;
            burst_cnt_d = '0;
            state_d     = GRANT;
          end else begin
            hrq_d   = 1'b0;
            state_d = RELEASE;
          end
        end
      end
      GRANT: begin
        if (transfer_done && terminal_count) tcs_d[active_channel] = 1'b1;
        if (!hold_acknowledge) begin
          hrq_d   = 1'b0;
          dack_d  = '1;
          owned_d = 1'b0;
          state_d = IDLE;
        end else if (transfer_done) begin
          burst_cnt_d = burst_cnt + 1'b1;
          if (terminal_count || !dma_request[active_channel] ||
              channel_mask[active_channel] || (burst_cnt == BURST_LAST)) begin
            hrq_d   = 1'b0;
            dack_d  = '1;
            owned_d = 1'b0;
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        hrq_d   = 1'b0;
        dack_d  = '1;
        owned_d = 1'b0;
        if (!hold_acknowledge) state_d = IDLE;
      end
      default: begin
        hrq_d   = 1'b0;
        dack_d  = '1;
        owned_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state                 <= IDLE;
      hold_request          <= 1'b0;
      dma_acknowledge_n     <= '1;
      active_channel        <= '0;
      bus_owned             <= 1'b0;
      terminal_count_status <= '0;
      burst_cnt             <= '0;
    end else begin
      state                 <= state_d;
      hold_request          <= hrq_d;
      dma_acknowledge_n     <= dack_d;
      active_channel        <= active_d;
      bus_owned             <= owned_d;
      terminal_count_status <= tcs_d;
      burst_cnt             <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb/tb_dma_channel_arbiter.sv - scoreboard bench for dma_channel_arbiter
module tb_dma_channel_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] dma_request, channel_mask;
  logic       hold_acknowledge, transfer_done, terminal_count, status_read;
  logic       hold_request, bus_owned;
  logic [3:0] dma_acknowledge_n, terminal_count_status;
  logic [1:0] active_channel;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0] dack_n;
    logic [1:0] chan;
  } grant_t;

  grant_t exp_grant_q[$];
  int     exp_rel_q[$];

  always #5 clock = ~clock;

  dma_channel_arbiter #(.CHANNELS(4), .BURST_LIMIT(4)) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .dma_request           (dma_request),
    .channel_mask          (channel_mask),
    .hold_acknowledge      (hold_acknowledge),
    .transfer_done         (transfer_done),
    .terminal_count        (terminal_count),
    .status_read           (status_read),
    .hold_request          (hold_request),
    .dma_acknowledge_n     (dma_acknowledge_n),
    .active_channel        (active_channel),
    .bus_owned             (bus_owned),
    .terminal_count_status (terminal_count_status)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic tcv, input logic srd);
    transfer_done  = 1'b1;
    terminal_count = tcv;
    status_read    = srd;
    tick();
    transfer_done  = 1'b0;
    terminal_count = 1'b0;
    status_read    = 1'b0;
  endtask

  task automatic expect_grant(input logic [3:0] dack, input logic [1:0] ch);
    grant_t g;
    g.dack_n = dack;
    g.chan   = ch;
    exp_grant_q.push_back(g);
  endtask

  task automatic expect_release(input int n);
    exp_rel_q.push_back(n);
  endtask

  // Monitor: checks each grant on bus_owned rising and the transfer count on falling.
  initial begin
    logic   prev;
    int     cnt;
    grant_t g;
    prev = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clock);
      if (bus_owned === 1'b1 && !prev) begin
        if (exp_grant_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_grant: got dack_n %b expected no grant", dma_acknowledge_n);
        end else begin
          g = exp_grant_q.pop_front();
          chk("grant_dack_n", dma_acknowledge_n, g.dack_n);
          chk("grant_channel", active_channel, g.chan);
        end
        cnt = 0;
      end
      if (bus_owned === 1'b1 && transfer_done) cnt++;
      if (bus_owned !== 1'b1 && prev) begin
        if (exp_rel_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_release: got %0d transfers expected none", cnt);
        end else begin
          chk("release_transfers", cnt, exp_rel_q.pop_front());
        end
        chk("release_dack_n", dma_acknowledge_n, 4'b1111);
      end
      prev = (bus_owned === 1'b1);
    end
  end

  initial begin
    logic [3:0] sec_dack, thr_dack;
    logic [1:0] sec_ch, thr_ch;
`ifdef DMA_ROTATING_PRIORITY_EN
    sec_ch = 2'd3; sec_dack = 4'b0111;
    thr_ch = 2'd1; thr_dack = 4'b1101;
`else
    sec_ch = 2'd1; sec_dack = 4'b1101;
    thr_ch = 2'd3; thr_dack = 4'b0111;
`endif
    reset_n = 1'b0; dma_request = '0; channel_mask = '0; hold_acknowledge = 1'b0;
    transfer_done = 1'b0; terminal_count = 1'b0; status_read = 1'b0;
    repeat (3) tick();
    chk("reset_hrq", hold_request, 1'b0);
    chk("reset_dack_n", dma_acknowledge_n, 4'b1111);
    chk("reset_active", active_channel, 2'd0);
    chk("reset_owned", bus_owned, 1'b0);
    chk("reset_tcs", terminal_count_status, 4'b0000);
    reset_n = 1'b1;
    tick();

    // Single request on channel 2, released by demand drop.
    dma_request = 4'b0100;
    tick();
    chk("t1_hrq", hold_request, 1'b1);
    chk("t1_no_dack_yet", dma_acknowledge_n, 4'b1111);
    expect_grant(4'b1011, 2'd2);
    hold_acknowledge = 1'b1;
    tick();
    chk("t1_owned", bus_owned, 1'b1);
    dma_request = 4'b0000;
    tick();
    chk("t1_drop_no_done", bus_owned, 1'b1);
    expect_release(1);
    pulse(1'b0, 1'b0);
    chk("t1_rel_hrq", hold_request, 1'b0);
    chk("t1_rel_owned", bus_owned, 1'b0);
    hold_acknowledge = 1'b0;
    tick();

    // Channels 1 and 3 competing.
    dma_request = 4'b1010;
    tick();
    chk("t2_hrq", hold_request, 1'b1);
    chk("t2_latched", active_channel, 2'd1);
    expect_grant(4'b1101, 2'd1);
    hold_acknowledge = 1'b1;
    tick();
    expect_release(1);
    pulse(1'b1, 1'b0);
    chk("t2_tcs", terminal_count_status, 4'b0010);
    hold_acknowledge = 1'b0;
    tick();
    tick();
    expect_grant(sec_dack, sec_ch);
    hold_acknowledge = 1'b1;
    tick();
    expect_release(1);
    dma_request[sec_ch] = 1'b0;
    pulse(1'b0, 1'b0);
    hold_acknowledge = 1'b0;
    tick();
    tick();
    expect_grant(thr_dack, thr_ch);
    hold_acknowledge = 1'b1;
    tick();
    expect_release(1);
    dma_request = 4'b0000;
    pulse(1'b0, 1'b0);
    hold_acknowledge = 1'b0;
    tick();
    status_read = 1'b1;
    tick();
    status_read = 1'b0;
    chk("t2_tcs_cleared", terminal_count_status, 4'b0000);

    // Burst limit of 4 on channel 0, then re-request.
    dma_request = 4'b0001;
    tick();
    expect_grant(4'b1110, 2'd0);
    hold_acknowledge = 1'b1;
    tick();
    expect_release(4);
    repeat (3) pulse(1'b0, 1'b0);
    chk("t3_not_early", bus_owned, 1'b1);
    pulse(1'b0, 1'b0);
    chk("t3_burst_release", bus_owned, 1'b0);
    chk("t3_burst_hrq", hold_request, 1'b0);
    hold_acknowledge = 1'b0;
    tick();
    tick();
    chk("t3_rerequest", hold_request, 1'b1);
    expect_grant(4'b1110, 2'd0);
    hold_acknowledge = 1'b1;
    tick();
    expect_release(1);
    dma_request = 4'b0000;
    pulse(1'b0, 1'b0);
    hold_acknowledge = 1'b0;
    tick();

    // Terminal count status set, and set beating a simultaneous clear.
    dma_request = 4'b0100;
    tick();
    expect_grant(4'b1011, 2'd2);
    hold_acknowledge = 1'b1;
    tick();
    expect_release(1);
    pulse(1'b1, 1'b0);
    chk("t4_tcs_ch2", terminal_count_status, 4'b0100);
    dma_request = 4'b0010;
    hold_acknowledge = 1'b0;
    tick();
    tick();
    expect_grant(4'b1101, 2'd1);
    hold_acknowledge = 1'b1;
    tick();
    expect_release(1);
    pulse(1'b1, 1'b1);
    chk("t4_tcs_set_wins", terminal_count_status, 4'b0010);
    dma_request = 4'b0000;
    hold_acknowledge = 1'b0;
    tick();

    // Request withdrawn before acknowledge: HRQ held, no DACK.
    dma_request = 4'b0001;
    tick();
    chk("t5_hrq", hold_request, 1'b1);
    dma_request = 4'b0000;
    tick();
    chk("t5_hrq_held1", hold_request, 1'b1);
    tick();
    chk("t5_hrq_held2", hold_request, 1'b1);
    hold_acknowledge = 1'b1;
    tick();
    chk("t5_rel_hrq", hold_request, 1'b0);
    chk("t5_rel_dack_n", dma_acknowledge_n, 4'b1111);
    chk("t5_rel_owned", bus_owned, 1'b0);
    hold_acknowledge = 1'b0;
    tick();

    // Reset in the middle of a grant.
    dma_request = 4'b1000;
    tick();
    expect_grant(4'b0111, 2'd3);
    hold_acknowledge = 1'b1;
    tick();
    chk("t6_owned", bus_owned, 1'b1);
    expect_release(0);
    reset_n = 1'b0;
    tick();
    chk("t6_hrq", hold_request, 1'b0);
    chk("t6_dack_n", dma_acknowledge_n, 4'b1111);
    chk("t6_active", active_channel, 2'd0);
    chk("t6_owned_low", bus_owned, 1'b0);
    chk("t6_tcs", terminal_count_status, 4'b0000);
    dma_request = 4'b0000;
    hold_acknowledge = 1'b0;
    reset_n = 1'b1;
    tick();

    // Hold acknowledge lost during grant: abort.
    dma_request = 4'b0100;
    tick();
    expect_grant(4'b1011, 2'd2);
    hold_acknowledge = 1'b1;
    tick();
    expect_release(0);
    hold_acknowledge = 1'b0;
    tick();
    chk("t7_dack_n", dma_acknowledge_n, 4'b1111);
    chk("t7_owned", bus_owned, 1'b0);
    chk("t7_hrq_gap", hold_request, 1'b0);
    tick();
    chk("t7_rerequest", hold_request, 1'b1);
    dma_request = 4'b0000;
    hold_acknowledge = 1'b1;
    tick();
    chk("t7_empty_release", bus_owned, 1'b0);
    hold_acknowledge = 1'b0;
    tick();

    repeat (3) tick();
    chk("grant_queue_drained", exp_grant_q.size(), 0);
    chk("release_queue_drained", exp_rel_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
